// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one MIPSALU between two requesters.
// Round-robin grant, operands latched at accept, one EXEC cycle, registered
// result handed back to the winner over a valid/ready handshake.
// Optional build macro ALU_OPCHECK_EN: illegal opcodes are flagged on rsp_err
// and replaced by a harmless AND of zeros.
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int CTL_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [CTL_W-1:0] req0_ctl,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [CTL_W-1:0] req1_ctl,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_out,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [CTL_W-1:0] alu_ctl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_prio;
    logic             r_gnt;
    logic [CTL_W-1:0] r_ctl;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_out;
    logic             r_zero;

    logic             w_gnt_any;
    logic             w_gnt_idx;
    logic             w_accept;
    logic             w_rsp_take;
    logic [CTL_W-1:0] w_sel_ctl;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;

`ifdef ALU_OPCHECK_EN
    logic             r_illegal;
    logic             r_err;
    logic             w_sel_legal;
`endif

    // The ALU is always driven straight from the latched operands.
    assign alu_ctl  = r_ctl;
    assign alu_a    = r_a;
    assign alu_b    = r_b;
    assign rsp_out  = r_out;
    assign rsp_zero = r_zero;

`ifdef ALU_OPCHECK_EN
    assign rsp_err = r_err;
`else
    assign rsp_err = 1'b0;
`endif

    // Round-robin grant: a lone requester always wins, a tie goes to prio.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = 1'b0;
        if (req0_valid && req1_valid) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = r_prio;
        end else if (req0_valid) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = 1'b0;
        end else if (req1_valid) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = 1'b1;
        end
    end

    // Mux the granted requester's operation towards the operand registers.
    always_comb begin
        w_sel_ctl = w_gnt_idx ? req1_ctl : req0_ctl;
        w_sel_a   = w_gnt_idx ? req1_a   : req0_a;
        w_sel_b   = w_gnt_idx ? req1_b   : req0_b;
    end

`ifdef ALU_OPCHECK_EN
    // Only the six MIPSALU opcodes are considered legal.
    always_comb begin
        w_sel_legal = (w_sel_ctl == CTL_W'(4'b0000)) ||
                      (w_sel_ctl == CTL_W'(4'b0001)) ||
                      (w_sel_ctl == CTL_W'(4'b0010)) ||
                      (w_sel_ctl == CTL_W'(4'b0110)) ||
                      (w_sel_ctl == CTL_W'(4'b0111)) ||
                      (w_sel_ctl == CTL_W'(4'b1100));
    end
`endif

    assign w_accept   = (r_state == IDLE) && w_gnt_any;
    assign w_rsp_take = r_gnt ? rsp1_ready : rsp0_ready;

    // State register for the IDLE -> EXEC -> RESP sequence.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake outputs; ready only in IDLE, valid only in RESP.
    always_comb begin
        w_next_state = r_state;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        rsp0_valid   = 1'b0;
        rsp1_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                req0_ready = w_gnt_any && !w_gnt_idx;
                req1_ready = w_gnt_any &&  w_gnt_idx;
                if (w_accept) begin
                    w_next_state = EXEC;
                end
            end
            EXEC: begin
                w_next_state = RESP;
            end
            RESP: begin
                rsp0_valid = !r_gnt;
                rsp1_valid =  r_gnt;
                if (w_rsp_take) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Operand latch at accept, result capture after EXEC, priority flip on completion.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_prio    <= 1'b0;
            r_gnt     <= 1'b0;
            r_ctl     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_out     <= '0;
            r_zero    <= 1'b0;
`ifdef ALU_OPCHECK_EN
            r_illegal <= 1'b0;
            r_err     <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_gnt <= w_gnt_idx;
`ifdef ALU_OPCHECK_EN
                if (w_sel_legal) begin
                    r_ctl     <= w_sel_ctl;
                    r_a       <= w_sel_a;
                    r_b       <= w_sel_b;
                    r_illegal <= 1'b0;
                end else begin
                    r_ctl     <= '0;
                    r_a       <= '0;
                    r_b       <= '0;
                    r_illegal <= 1'b1;
                end
`else
                r_ctl <= w_sel_ctl;
                r_a   <= w_sel_a;
                r_b   <= w_sel_b;
`endif
            end
            if (r_state == EXEC) begin
`ifdef ALU_OPCHECK_EN
                if (r_illegal) begin
                    r_out  <= '0;
                    r_zero <= 1'b1;
                    r_err  <= 1'b1;
                end else begin
                    r_out  <= alu_out;
                    r_zero <= alu_zero;
                    r_err  <= 1'b0;
                end
`else
                r_out  <= alu_out;
                r_zero <= alu_zero;
`endif
            end
            if ((r_state == RESP) && w_rsp_take) begin
                r_prio <= ~r_gnt;
`ifdef ALU_OPCHECK_EN
                r_err  <= 1'b0;
`endif
            end
        end
    end

endmodule
